secuenciador_desplazamiento_display: RTL and testbench

SECUENCIADOR_DESPLAZAMIENTO_DISPLAY -- requirements
Module: secuenciador_desplazamiento_display

---
 rtl/secuenciador_desplazamiento_display.sv | 122 ++++++++++++
 tb/tb_secuenciador_desplazamiento_display.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_desplazamiento_display.sv
// Scrolling message sequencer: loads up to 8 nibbles, then rotates a 4-digit window
// across the message once every DIVISOR clock cycles.
module secuenciador_desplazamiento_display #(
    parameter int DIVISOR      = 50000000,
    parameter int LONGITUD_MAX = 8
) (
    input  logic       i_Reloj,
    input  logic       i_Reset,
    input  logic [3:0] i_Dato,
    input  logic       i_Valido,
    input  logic       i_Ultimo,
    output logic       o_Listo,
    input  logic       i_Iniciar,
    input  logic       i_Detener,
    input  logic       i_Borrar,
    output logic [3:0] o_Datos_3,
    output logic [3:0] o_Datos_2,
    output logic [3:0] o_Datos_1,
    output logic [3:0] o_Datos_0,
    output logic       o_Ocupado,
    output logic       o_Vuelta
);

    localparam int                   PRESC_W   = $clog2(DIVISOR);
    localparam logic [PRESC_W-1:0]   PRESC_FIN = PRESC_W'(DIVISOR - 1);
    localparam logic [3:0]           LMAX      = 4'(LONGITUD_MAX);

    typedef enum logic [1:0] {INACTIVO, CARGA, PAUSA, DESPLAZA} estado_t;

    estado_t              estado;
    logic [3:0]           longitud;
    logic [2:0]           posicion;
    logic [PRESC_W-1:0]   prescaler;
    logic [3:0]           buffer [8];
    logic                 acepta;

    // (pos + k) mod lon for pos < lon and k <= 3; at most three subtractions are needed
    function automatic logic [2:0] indice(input logic [2:0] pos, input logic [1:0] k,
                                          input logic [3:0] lon);
        logic [3:0] s;
        s = {1'b0, pos} + {2'b00, k};
        for (int i = 0; i < 3; i++) begin
            if (lon != 4'd0 && s >= lon) s = s - lon;
        end
        return s[2:0];
    endfunction

    assign o_Listo   = (estado == INACTIVO) || (estado == CARGA && longitud < LMAX);
    assign o_Ocupado = (estado == DESPLAZA);
    assign acepta    = i_Valido && o_Listo && !i_Reset && !i_Borrar;

    always_ff @(posedge i_Reloj) begin
        if (acepta) buffer[longitud[2:0]] <= i_Dato;
    end

    always_ff @(posedge i_Reloj) begin
        if (i_Reset) begin
            estado    <= INACTIVO;
            longitud  <= 4'd0;
            posicion  <= 3'd0;
            prescaler <= '0;
            o_Vuelta  <= 1'b0;
        end else begin
            o_Vuelta <= 1'b0;
            if (i_Borrar) begin
                estado    <= INACTIVO;
                longitud  <= 4'd0;
                posicion  <= 3'd0;
                prescaler <= '0;
            end else begin
                case (estado)
                    INACTIVO, CARGA: begin
                        if (acepta) begin
                            longitud <= longitud + 4'd1;
                            if (i_Ultimo || longitud == LMAX - 4'd1) estado <= PAUSA;
                            else                                     estado <= CARGA;
                        end
                    end
                    PAUSA: begin
                        if (i_Iniciar) begin
                            estado    <= DESPLAZA;
                            prescaler <= '0;
                        end
                    end
                    DESPLAZA: begin
                        if (prescaler == PRESC_FIN) begin
                            prescaler <= '0;
                            if ({1'b0, posicion} == longitud - 4'd1) begin
                                posicion <= 3'd0;
                                o_Vuelta <= 1'b1;
                            end else begin
                                posicion <= posicion + 3'd1;
                            end
                        end else begin
                            prescaler <= prescaler + PRESC_W'(1);
                        end
                        // A stop in the step cycle still keeps the stepped position
                        if (i_Detener) begin
                            estado    <= PAUSA;
                            prescaler <= '0;
                        end
                    end
                    default: estado <= INACTIVO;
                endcase
            end
        end
    end

    always_comb begin
        o_Datos_3 = 4'h0;
        o_Datos_2 = 4'h0;
        o_Datos_1 = 4'h0;
        o_Datos_0 = 4'h0;
        if (estado == PAUSA || estado == DESPLAZA) begin
            o_Datos_3 = buffer[indice(posicion, 2'd0, longitud)];
            o_Datos_2 = buffer[indice(posicion, 2'd1, longitud)];
            o_Datos_1 = buffer[indice(posicion, 2'd2, longitud)];
            o_Datos_0 = buffer[indice(posicion, 2'd3, longitud)];
        end
    end

endmodule

// File: tb/tb_secuenciador_desplazamiento_display.sv
// Self-checking bench for the scrolling sequencer with DIVISOR=4 (one step every 4 cycles).
module tb_secuenciador_desplazamiento_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dato;
    logic       valido, ultimo, iniciar, detener, borrar;
    logic       listo, ocupado, vuelta;
    logic [3:0] d3, d2, d1, d0;
    logic [15:0] ventana;

    int tests  = 0;
    int fallos = 0;
    logic [3:0]  msg [8];
    int          mlen = 1;
    logic [15:0] esperado_q [$];
    logic [15:0] exp_v;
    int          nv;

    always #5 clk = ~clk;
    assign ventana = {d3, d2, d1, d0};

    secuenciador_desplazamiento_display #(.DIVISOR(4), .LONGITUD_MAX(8)) dut (
        .i_Reloj(clk), .i_Reset(rst), .i_Dato(dato), .i_Valido(valido), .i_Ultimo(ultimo),
        .o_Listo(listo), .i_Iniciar(iniciar), .i_Detener(detener), .i_Borrar(borrar),
        .o_Datos_3(d3), .o_Datos_2(d2), .o_Datos_1(d1), .o_Datos_0(d0),
        .o_Ocupado(ocupado), .o_Vuelta(vuelta)
    );

    function automatic logic [15:0] modelo(input int pos);
        logic [15:0] r;
        r = 16'h0;
        for (int k = 0; k < 4; k++) r = {r[11:0], msg[(pos + k) % mlen]};
        return r;
    endfunction

    task automatic paso();
        @(posedge clk);
        #1;
        if (vuelta === 1'b1) nv++;
    endtask

    task automatic ciclos(input int n);
        for (int i = 0; i < n; i++) paso();
    endtask

    task automatic reposo();
        valido = 0; ultimo = 0; iniciar = 0; detener = 0; borrar = 0; dato = 4'h0;
    endtask

    task automatic cargar(input logic [3:0] d, input logic u);
        valido = 1; dato = d; ultimo = u;
        paso();
        valido = 0; ultimo = 0;
    endtask

    task automatic arrancar();
        iniciar = 1;
        paso();
        iniciar = 0;
        nv = 0;
    endtask

    task automatic test_reset();
        reposo();
        rst = 1;
        ciclos(2);
        tests++; if (listo !== 1'b1) begin fallos++; $display("FAIL reset_listo: got %b want 1", listo); end
        tests++; if (ventana !== 16'h0) begin fallos++; $display("FAIL reset_datos: got %h want 0000", ventana); end
        tests++; if (ocupado !== 1'b0) begin fallos++; $display("FAIL reset_ocupado: got %b want 0", ocupado); end
        tests++; if (vuelta !== 1'b0) begin fallos++; $display("FAIL reset_vuelta: got %b want 0", vuelta); end
        rst = 0;
        paso();
        tests++; if (listo !== 1'b1) begin fallos++; $display("FAIL post_reset_listo: got %b want 1", listo); end
    endtask

    task automatic test_carga();
        mlen = 5;
        for (int i = 0; i < 5; i++) msg[i] = 4'(i + 1);
        cargar(4'h1, 1'b0);
        tests++; if (listo !== 1'b1 || ventana !== 16'h0) begin
            fallos++; $display("FAIL carga_intermedia: listo=%b datos=%h want 1/0000", listo, ventana); end
        // Start in CARGA must be ignored
        iniciar = 1; paso(); iniciar = 0;
        cargar(4'h2, 1'b0); cargar(4'h3, 1'b0); cargar(4'h4, 1'b0); cargar(4'h5, 1'b1);
        esperado_q.push_back(modelo(0));
        tests++; if (listo !== 1'b0) begin fallos++; $display("FAIL carga_listo: got %b want 0", listo); end
        tests++; if (ocupado !== 1'b0) begin fallos++; $display("FAIL carga_ocupado: got %b want 0", ocupado); end
        exp_v = esperado_q.pop_front();
        tests++; if (ventana !== exp_v) begin fallos++; $display("FAIL carga_ventana: got %h want %h", ventana, exp_v); end
    endtask

    task automatic test_desplaza();
        arrancar();
        tests++; if (ocupado !== 1'b1) begin fallos++; $display("FAIL desplaza_ocupado: got %b want 1", ocupado); end
        esperado_q.push_back(modelo(1));
        esperado_q.push_back(modelo(2));
        esperado_q.push_back(modelo(0));
        ciclos(4);
        exp_v = esperado_q.pop_front();
        tests++; if (ventana !== exp_v) begin fallos++; $display("FAIL desplaza_paso1: got %h want %h", ventana, exp_v); end
        ciclos(4);
        exp_v = esperado_q.pop_front();
        tests++; if (ventana !== exp_v) begin fallos++; $display("FAIL desplaza_paso2: got %h want %h", ventana, exp_v); end
        ciclos(12);
        exp_v = esperado_q.pop_front();
        tests++; if (ventana !== exp_v) begin fallos++; $display("FAIL desplaza_vuelta_ventana: got %h want %h", ventana, exp_v); end
        tests++; if (nv !== 1) begin fallos++; $display("FAIL desplaza_vuelta_pulsos: got %0d want 1", nv); end
    endtask

    task automatic test_detener();
        detener = 1; paso(); detener = 0;
        tests++; if (ocupado !== 1'b0) begin fallos++; $display("FAIL detener_ocupado: got %b want 0", ocupado); end
        esperado_q.push_back(modelo(0));
        exp_v = esperado_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            paso();
            tests++; if (ventana !== exp_v) begin fallos++; $display("FAIL detener_hold%0d: got %h want %h", i, ventana, exp_v); end
        end
        // Stop requested in the very cycle of a step keeps the stepped position
        arrancar();
        ciclos(3);
        detener = 1; paso(); detener = 0;
        esperado_q.push_back(modelo(1));
        exp_v = esperado_q.pop_front();
        tests++; if (ocupado !== 1'b0 || ventana !== exp_v) begin
            fallos++; $display("FAIL detener_en_paso: ocupado=%b datos=%h want 0/%h", ocupado, ventana, exp_v); end
        ciclos(6);
        tests++; if (ventana !== exp_v) begin fallos++; $display("FAIL detener_en_paso_hold: got %h want %h", ventana, exp_v); end
    endtask

    task automatic test_corto();
        borrar = 1; paso(); borrar = 0;
        tests++; if (listo !== 1'b1 || ventana !== 16'h0) begin
            fallos++; $display("FAIL borrar: listo=%b datos=%h want 1/0000", listo, ventana); end
        mlen = 2; msg[0] = 4'h9; msg[1] = 4'hA;
        cargar(4'h9, 1'b0); cargar(4'hA, 1'b1);
        esperado_q.push_back(modelo(0));
        exp_v = esperado_q.pop_front();
        tests++; if (ventana !== exp_v) begin fallos++; $display("FAIL corto_ventana: got %h want %h", ventana, exp_v); end
        arrancar();
        esperado_q.push_back(modelo(1));
        esperado_q.push_back(modelo(0));
        ciclos(4);
        exp_v = esperado_q.pop_front();
        tests++; if (ventana !== exp_v || nv !== 0) begin
            fallos++; $display("FAIL corto_paso1: datos=%h vueltas=%0d want %h/0", ventana, nv, exp_v); end
        ciclos(4);
        exp_v = esperado_q.pop_front();
        tests++; if (ventana !== exp_v || nv !== 1) begin
            fallos++; $display("FAIL corto_paso2: datos=%h vueltas=%0d want %h/1", ventana, nv, exp_v); end
        ciclos(8);
        tests++; if (nv !== 2) begin fallos++; $display("FAIL corto_vueltas: got %0d want 2", nv); end
    endtask

    task automatic test_prioridad();
        borrar = 1; detener = 1; iniciar = 1;
        paso();
        reposo();
        tests++; if (ocupado !== 1'b0 || ventana !== 16'h0 || listo !== 1'b1) begin
            fallos++; $display("FAIL prioridad: ocupado=%b datos=%h listo=%b want 0/0000/1", ocupado, ventana, listo); end
    endtask

    task automatic test_lleno();
        mlen = 8;
        for (int i = 0; i < 8; i++) begin
            msg[i] = 4'(i);
            cargar(4'(i), 1'b0);
        end
        esperado_q.push_back(modelo(0));
        tests++; if (listo !== 1'b0 || ocupado !== 1'b0) begin
            fallos++; $display("FAIL lleno_listo: listo=%b ocupado=%b want 0/0", listo, ocupado); end
        cargar(4'hF, 1'b1);
        exp_v = esperado_q.pop_front();
        tests++; if (ventana !== exp_v) begin fallos++; $display("FAIL lleno_ventana: got %h want %h", ventana, exp_v); end
        arrancar();
        esperado_q.push_back(modelo(1));
        esperado_q.push_back(modelo(0));
        ciclos(4);
        exp_v = esperado_q.pop_front();
        tests++; if (ventana !== exp_v) begin fallos++; $display("FAIL lleno_paso1: got %h want %h", ventana, exp_v); end
        ciclos(28);
        exp_v = esperado_q.pop_front();
        tests++; if (ventana !== exp_v || nv !== 1) begin
            fallos++; $display("FAIL lleno_vuelta: datos=%h vueltas=%0d want %h/1", ventana, nv, exp_v); end
    endtask

    task automatic test_reset_medio();
        ciclos(2);
        rst = 1; iniciar = 1; valido = 1;
        paso();
        rst = 0; reposo();
        tests++; if (ocupado !== 1'b0 || vuelta !== 1'b0 || ventana !== 16'h0 || listo !== 1'b1) begin
            fallos++; $display("FAIL reset_medio: ocupado=%b vuelta=%b datos=%h listo=%b want 0/0/0000/1",
                               ocupado, vuelta, ventana, listo); end
        mlen = 1; msg[0] = 4'h7;
        cargar(4'h7, 1'b1);
        esperado_q.push_back(modelo(0));
        exp_v = esperado_q.pop_front();
        tests++; if (ventana !== exp_v) begin fallos++; $display("FAIL recarga_7: got %h want %h", ventana, exp_v); end
        arrancar();
        ciclos(8);
        tests++; if (nv !== 2 || ventana !== exp_v) begin
            fallos++; $display("FAIL uno_vueltas: vueltas=%0d datos=%h want 2/%h", nv, ventana, exp_v); end
    endtask

    initial begin
        nv = 0;
        rst = 1;
        reposo();
        test_reset();
        test_carga();
        test_desplaza();
        test_detener();
        test_corto();
        arrancar();
        ciclos(2);
        test_prioridad();
        test_lleno();
        test_reset_medio();
        $display("[TB] %0d tests run, %0d failed", tests, fallos);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
